// File: rtl/vga_fb_port_arbiter.sv
// vga_fb_port_arbiter: shares a single-port 16-colour frame buffer between
// the VGA scan-out reader (never stalls) and a valid/ready pixel writer.
// Each memory word holds two CGA indices: even pixel [3:0], odd pixel [7:4].
// A one-word read cache serves scan pixels that hit the current word, which
// frees memory slots for the writer.
// Optional build macro FB_CLEAR_EN adds a whole-buffer clear engine
// (i_Clear, i_Clear_Color, o_Clear_Busy).
module vga_fb_port_arbiter #(
  parameter int PIX_ADDR_WIDTH = 13
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic                      i_Scan_Req,
  input  logic [PIX_ADDR_WIDTH-1:0] i_Scan_Addr,
  output logic [3:0]                o_Scan_Color,
  output logic                      o_Scan_Valid,
  input  logic                      i_Wr_Valid,
  input  logic [PIX_ADDR_WIDTH-1:0] i_Wr_Addr,
  input  logic [3:0]                i_Wr_Color,
  output logic                      o_Wr_Ready,
  output logic [PIX_ADDR_WIDTH-2:0] o_Mem_Addr,
  output logic                      o_Mem_Rd_En,
  output logic                      o_Mem_Wr_En,
  output logic [1:0]                o_Mem_Wr_Mask,
  output logic [7:0]                o_Mem_Wr_Data,
  input  logic [7:0]                i_Mem_Rd_Data
`ifdef FB_CLEAR_EN
  ,
  input  logic                      i_Clear,
  input  logic [3:0]                i_Clear_Color,
  output logic                      o_Clear_Busy
`endif
);

  localparam int WORD_W = PIX_ADDR_WIDTH - 1;

  logic [WORD_W-1:0] scanWord;
  logic [WORD_W-1:0] wrWord;
  logic              cacheValid;
  logic [WORD_W-1:0] cacheTag;
  logic [7:0]        cacheData;
  logic [7:0]        cacheDataNext;
  logic              loadPending;
  logic              scanNeed;
  logic              clearing;
  logic [WORD_W-1:0] clearPtr;
  logic [3:0]        clearColor;
  logic              s1Valid;
  logic              s1Odd;
  logic              s1Miss;
  logic [7:0]        s2Word;

  assign scanWord = i_Scan_Addr[PIX_ADDR_WIDTH-1:1];
  assign wrWord   = i_Wr_Addr[PIX_ADDR_WIDTH-1:1];
  // Parity never forces a read: only an invalid cache or a different word does.
  assign scanNeed = !i_Reset && i_Scan_Req && (!cacheValid || (cacheTag != scanWord));

`ifdef FB_CLEAR_EN
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t            state;
  state_t            stateNext;
  logic [WORD_W-1:0] ptrNext;
  logic [3:0]        colorNext;

  // Clear engine state, pointer and latched colour.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state      <= ST_IDLE;
      clearPtr   <= '0;
      clearColor <= '0;
    end else begin
      state      <= stateNext;
      clearPtr   <= ptrNext;
      clearColor <= colorNext;
    end
  end

  // Clear sequencing: advance the pointer on every slot scan leaves free.
  always_comb begin
    stateNext = state;
    ptrNext   = clearPtr;
    colorNext = clearColor;
    case (state)
      ST_IDLE: begin
        if (i_Clear) begin
          stateNext = ST_CLEAR;
          ptrNext   = '0;
          colorNext = i_Clear_Color;
        end
      end
      ST_CLEAR: begin
        if (!scanNeed) begin
          ptrNext = clearPtr + 1'b1;
          if (clearPtr == '1) stateNext = ST_IDLE;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  assign clearing     = (state == ST_CLEAR);
  assign o_Clear_Busy = clearing && !i_Reset;
`else
  assign clearing   = 1'b0;
  assign clearPtr   = '0;
  assign clearColor = '0;
`endif

  // Port arbitration: scan misses first, then clear, then the writer.
  always_comb begin
    o_Wr_Ready    = 1'b0;
    o_Mem_Addr    = '0;
    o_Mem_Rd_En   = 1'b0;
    o_Mem_Wr_En   = 1'b0;
    o_Mem_Wr_Mask = '0;
    o_Mem_Wr_Data = '0;
    if (!i_Reset) begin
      o_Wr_Ready = !scanNeed && !clearing;
      if (scanNeed) begin
        o_Mem_Rd_En = 1'b1;
        o_Mem_Addr  = scanWord;
      end else if (clearing) begin
        o_Mem_Wr_En   = 1'b1;
        o_Mem_Addr    = clearPtr;
        o_Mem_Wr_Mask = 2'b11;
        o_Mem_Wr_Data = {clearColor, clearColor};
      end else if (i_Wr_Valid) begin
        o_Mem_Wr_En   = 1'b1;
        o_Mem_Addr    = wrWord;
        o_Mem_Wr_Mask = i_Wr_Addr[0] ? 2'b10 : 2'b01;
        o_Mem_Wr_Data = {i_Wr_Color, i_Wr_Color};
      end
    end
  end

  // The tag moves at the miss edge so the next pixel of the same word hits;
  // the data lands one edge later, and any same-cycle write overlays it.
  always_comb begin
    cacheDataNext = loadPending ? i_Mem_Rd_Data : cacheData;
    if (o_Mem_Wr_En && cacheValid && (cacheTag == o_Mem_Addr)) begin
      if (o_Mem_Wr_Mask[0]) cacheDataNext[3:0] = o_Mem_Wr_Data[3:0];
      if (o_Mem_Wr_Mask[1]) cacheDataNext[7:4] = o_Mem_Wr_Data[7:4];
    end
  end

  // Cache tag/data registers.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      cacheValid  <= 1'b0;
      cacheTag    <= '0;
      cacheData   <= '0;
      loadPending <= 1'b0;
    end else begin
      cacheData   <= cacheDataNext;
      loadPending <= scanNeed;
      if (scanNeed) begin
        cacheTag   <= scanWord;
        cacheValid <= 1'b1;
      end
    end
  end

  assign s2Word = s1Miss ? i_Mem_Rd_Data : cacheData;

  // Two-stage scan pipeline: fixed latency for both hits and misses.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      s1Valid      <= 1'b0;
      s1Odd        <= 1'b0;
      s1Miss       <= 1'b0;
      o_Scan_Valid <= 1'b0;
      o_Scan_Color <= '0;
    end else begin
      s1Valid      <= i_Scan_Req;
      s1Odd        <= i_Scan_Addr[0];
      s1Miss       <= scanNeed;
      o_Scan_Valid <= s1Valid;
      if (s1Valid) o_Scan_Color <= s1Odd ? s2Word[7:4] : s2Word[3:0];
    end
  end

endmodule

// File: tb/tb_vga_fb_port_arbiter.sv
// Directed self-checking bench for vga_fb_port_arbiter with a behavioural
// single-port memory (word0=8'h21, word1=8'h43, rest 0 after each reset).
module tb_vga_fb_port_arbiter;

`ifdef FB_CLEAR_EN
  localparam int PAW = 4;
`else
  localparam int PAW = 13;
`endif
  localparam int WW     = PAW - 1;
  localparam int NWORDS = 1 << WW;

  logic           i_Clk;
  logic           i_Reset;
  logic           i_Scan_Req;
  logic [PAW-1:0] i_Scan_Addr;
  logic [3:0]     o_Scan_Color;
  logic           o_Scan_Valid;
  logic           i_Wr_Valid;
  logic [PAW-1:0] i_Wr_Addr;
  logic [3:0]     i_Wr_Color;
  logic           o_Wr_Ready;
  logic [WW-1:0]  o_Mem_Addr;
  logic           o_Mem_Rd_En;
  logic           o_Mem_Wr_En;
  logic [1:0]     o_Mem_Wr_Mask;
  logic [7:0]     o_Mem_Wr_Data;
  logic [7:0]     i_Mem_Rd_Data;
`ifdef FB_CLEAR_EN
  logic           i_Clear;
  logic [3:0]     i_Clear_Color;
  logic           o_Clear_Busy;
`endif

  int checks = 0;
  int errors = 0;

  vga_fb_port_arbiter #(.PIX_ADDR_WIDTH(PAW)) dut (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .i_Scan_Req   (i_Scan_Req),
    .i_Scan_Addr  (i_Scan_Addr),
    .o_Scan_Color (o_Scan_Color),
    .o_Scan_Valid (o_Scan_Valid),
    .i_Wr_Valid   (i_Wr_Valid),
    .i_Wr_Addr    (i_Wr_Addr),
    .i_Wr_Color   (i_Wr_Color),
    .o_Wr_Ready   (o_Wr_Ready),
    .o_Mem_Addr   (o_Mem_Addr),
    .o_Mem_Rd_En  (o_Mem_Rd_En),
    .o_Mem_Wr_En  (o_Mem_Wr_En),
    .o_Mem_Wr_Mask(o_Mem_Wr_Mask),
    .o_Mem_Wr_Data(o_Mem_Wr_Data),
    .i_Mem_Rd_Data(i_Mem_Rd_Data)
`ifdef FB_CLEAR_EN
    ,
    .i_Clear      (i_Clear),
    .i_Clear_Color(i_Clear_Color),
    .o_Clear_Busy (o_Clear_Busy)
`endif
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Behavioural frame-buffer memory, 1-cycle read latency, nibble-masked writes.
  logic [7:0] mem [NWORDS];
  always @(posedge i_Clk) begin
    if (i_Reset) begin
      for (int w = 0; w < NWORDS; w++)
        mem[w] <= (w == 0) ? 8'h21 : ((w == 1) ? 8'h43 : 8'h00);
      i_Mem_Rd_Data <= '0;
    end else begin
      if (o_Mem_Rd_En) i_Mem_Rd_Data <= mem[o_Mem_Addr];
      if (o_Mem_Wr_En) begin
        if (o_Mem_Wr_Mask[0]) mem[o_Mem_Addr][3:0] <= o_Mem_Wr_Data[3:0];
        if (o_Mem_Wr_Mask[1]) mem[o_Mem_Addr][7:4] <= o_Mem_Wr_Data[7:4];
      end
    end
  end

  // Read and write strobes must never coincide.
  always @(negedge i_Clk) begin
    checks++;
    if ((o_Mem_Rd_En & o_Mem_Wr_En) !== 1'b0) begin
      errors++;
      $display("FAIL port_exclusive: rd=%b wr=%b, required not both 1", o_Mem_Rd_En, o_Mem_Wr_En);
    end
  end

  task automatic cycle();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic test_reset();
    i_Reset = 1'b1; i_Wr_Valid = 1'b1; i_Wr_Addr = PAW'(5); i_Wr_Color = 4'hA;
    i_Scan_Req = 1'b1; i_Scan_Addr = '0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      #1;
      checks++;
      if ({o_Wr_Ready, o_Mem_Rd_En, o_Mem_Wr_En, o_Scan_Valid, o_Mem_Wr_Mask,
           o_Mem_Wr_Data, o_Scan_Color, o_Mem_Addr} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: ready=%b rd=%b wr=%b valid=%b mask=%b data=%h color=%h addr=%h, required all 0",
                 o_Wr_Ready, o_Mem_Rd_En, o_Mem_Wr_En, o_Scan_Valid, o_Mem_Wr_Mask,
                 o_Mem_Wr_Data, o_Scan_Color, o_Mem_Addr);
      end
    end
    i_Reset = 1'b0; i_Wr_Valid = 1'b0; i_Scan_Req = 1'b0;
    #1;
    checks++;
    if (o_Wr_Ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b required 1", o_Wr_Ready);
    end
  endtask

  // Pixels 0..3 back to back: reads only on even pixels, colours 1,2,3,4.
  task automatic test_scan_read();
    for (int i = 0; i < 8; i++) begin
      cycle();
      i_Scan_Req  = (i < 4);
      i_Scan_Addr = PAW'(i);
      #1;
      if (i < 4) begin
        checks++;
        if (o_Mem_Rd_En !== ((i % 2) == 0)) begin
          errors++;
          $display("FAIL scan_rd_en[%0d]: got %b required %b", i, o_Mem_Rd_En, (i % 2) == 0);
        end
        if ((i % 2) == 0) begin
          checks++;
          if (o_Mem_Addr !== WW'(i / 2)) begin
            errors++;
            $display("FAIL scan_rd_addr[%0d]: got %h required %h", i, o_Mem_Addr, i / 2);
          end
        end
      end
      if (i >= 2 && i < 6) begin
        checks++;
        if (o_Scan_Valid !== 1'b1 || o_Scan_Color !== 4'(i - 1)) begin
          errors++;
          $display("FAIL scan_color[%0d]: got valid=%b color=%h required valid=1 color=%h",
                   i, o_Scan_Valid, o_Scan_Color, i - 1);
        end
      end
      if (i >= 6) begin
        checks++;
        if (o_Scan_Valid !== 1'b0 || o_Scan_Color !== 4'h4) begin
          errors++;
          $display("FAIL scan_hold[%0d]: got valid=%b color=%h required valid=0 color=4",
                   i, o_Scan_Valid, o_Scan_Color);
        end
      end
    end
  endtask

  // Writer stalls on the pixel-0 miss and is granted on the pixel-1 hit.
  task automatic test_write_stall();
    cycle();
    i_Scan_Req = 1'b1; i_Scan_Addr = PAW'(0);
    i_Wr_Valid = 1'b1; i_Wr_Addr = PAW'(5); i_Wr_Color = 4'hA;
    #1;
    checks++;
    if (o_Wr_Ready !== 1'b0 || o_Mem_Wr_En !== 1'b0 || o_Mem_Rd_En !== 1'b1) begin
      errors++;
      $display("FAIL stall_slot: got ready=%b wr=%b rd=%b required ready=0 wr=0 rd=1",
               o_Wr_Ready, o_Mem_Wr_En, o_Mem_Rd_En);
    end
    cycle();
    i_Scan_Addr = PAW'(1);
    #1;
    checks++;
    if (o_Wr_Ready !== 1'b1 || o_Mem_Wr_En !== 1'b1 || o_Mem_Rd_En !== 1'b0 ||
        o_Mem_Addr !== WW'(2) || o_Mem_Wr_Mask !== 2'b10 || o_Mem_Wr_Data !== 8'hAA) begin
      errors++;
      $display("FAIL grant_slot: got ready=%b wr=%b rd=%b addr=%h mask=%b data=%h required 1 1 0 2 10 aa",
               o_Wr_Ready, o_Mem_Wr_En, o_Mem_Rd_En, o_Mem_Addr, o_Mem_Wr_Mask, o_Mem_Wr_Data);
    end
    cycle();
    i_Scan_Req = 1'b0; i_Wr_Valid = 1'b0;
    #1;
    checks++;
    if (o_Scan_Valid !== 1'b1 || o_Scan_Color !== 4'h1) begin
      errors++;
      $display("FAIL stall_scan0: got valid=%b color=%h required 1 1", o_Scan_Valid, o_Scan_Color);
    end
    cycle();
    #1;
    checks++;
    if (o_Scan_Valid !== 1'b1 || o_Scan_Color !== 4'h2) begin
      errors++;
      $display("FAIL stall_scan1: got valid=%b color=%h required 1 2", o_Scan_Valid, o_Scan_Color);
    end
  endtask

  // Write to the cached word is visible to a later hit without a memory read.
  task automatic test_coherent_write();
    cycle();
    i_Wr_Valid = 1'b1; i_Wr_Addr = PAW'(1); i_Wr_Color = 4'hF;
    #1;
    checks++;
    if (o_Mem_Wr_En !== 1'b1 || o_Mem_Wr_Mask !== 2'b10 || o_Mem_Addr !== WW'(0)) begin
      errors++;
      $display("FAIL coh_write: got wr=%b mask=%b addr=%h required 1 10 0", o_Mem_Wr_En, o_Mem_Wr_Mask, o_Mem_Addr);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      i_Wr_Valid = 1'b0;
      i_Scan_Req = (i < 2);
      i_Scan_Addr = (i == 0) ? PAW'(1) : PAW'(0);
      #1;
      if (i < 2) begin
        checks++;
        if (o_Mem_Rd_En !== 1'b0) begin
          errors++;
          $display("FAIL coh_no_read[%0d]: got rd=%b required 0", i, o_Mem_Rd_En);
        end
      end else begin
        checks++;
        if (o_Scan_Valid !== 1'b1 || o_Scan_Color !== ((i == 2) ? 4'hF : 4'h1)) begin
          errors++;
          $display("FAIL coh_color[%0d]: got valid=%b color=%h required 1 %h",
                   i, o_Scan_Valid, o_Scan_Color, (i == 2) ? 4'hF : 4'h1);
        end
      end
    end
  endtask

  // Write lands on the cycle the miss data loads; the written nibble must win.
  task automatic test_overlay();
    cycle();
    i_Scan_Req = 1'b1; i_Scan_Addr = PAW'(2);
    #1;
    checks++;
    if (o_Mem_Rd_En !== 1'b1 || o_Mem_Addr !== WW'(1)) begin
      errors++;
      $display("FAIL ovl_read: got rd=%b addr=%h required 1 1", o_Mem_Rd_En, o_Mem_Addr);
    end
    cycle();
    i_Scan_Req = 1'b0;
    i_Wr_Valid = 1'b1; i_Wr_Addr = PAW'(3); i_Wr_Color = 4'h9;
    #1;
    checks++;
    if (o_Wr_Ready !== 1'b1 || o_Mem_Wr_En !== 1'b1 || o_Mem_Addr !== WW'(1) || o_Mem_Wr_Data !== 8'h99) begin
      errors++;
      $display("FAIL ovl_write: got ready=%b wr=%b addr=%h data=%h required 1 1 1 99",
               o_Wr_Ready, o_Mem_Wr_En, o_Mem_Addr, o_Mem_Wr_Data);
    end
    cycle();
    i_Wr_Valid = 1'b0;
    i_Scan_Req = 1'b1; i_Scan_Addr = PAW'(3);
    #1;
    checks++;
    if (o_Mem_Rd_En !== 1'b0 || o_Scan_Valid !== 1'b1 || o_Scan_Color !== 4'h3) begin
      errors++;
      $display("FAIL ovl_hit_and_pix2: got rd=%b valid=%b color=%h required 0 1 3",
               o_Mem_Rd_En, o_Scan_Valid, o_Scan_Color);
    end
    cycle();
    i_Scan_Req = 1'b0;
    cycle();
    #1;
    checks++;
    if (o_Scan_Valid !== 1'b1 || o_Scan_Color !== 4'h9) begin
      errors++;
      $display("FAIL ovl_color: got valid=%b color=%h required 1 9", o_Scan_Valid, o_Scan_Color);
    end
  endtask

  // Reset mid-flight drops the pending result and invalidates the cache.
  task automatic test_reset_flush();
    cycle();
    i_Scan_Req = 1'b1; i_Scan_Addr = PAW'(0);
    cycle();
    i_Reset = 1'b1; i_Scan_Req = 1'b0;
    cycle();
    i_Reset = 1'b0;
    i_Scan_Req = 1'b1; i_Scan_Addr = PAW'(3);
    #1;
    checks++;
    if (o_Scan_Valid !== 1'b0 || o_Mem_Rd_En !== 1'b1) begin
      errors++;
      $display("FAIL flush_drop: got valid=%b rd=%b required valid=0 rd=1", o_Scan_Valid, o_Mem_Rd_En);
    end
    cycle();
    i_Scan_Req = 1'b0;
    #1;
    checks++;
    if (o_Scan_Valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: got valid=%b required 0", o_Scan_Valid);
    end
    cycle();
    #1;
    checks++;
    if (o_Scan_Valid !== 1'b1 || o_Scan_Color !== 4'h4) begin
      errors++;
      $display("FAIL flush_reload: got valid=%b color=%h required 1 4", o_Scan_Valid, o_Scan_Color);
    end
  endtask

`ifdef FB_CLEAR_EN
  // Clear with colour 7 interleaved with missing even-pixel scans.
  task automatic test_clear();
    int expPtr = 0;
    logic busyExp;
    cycle();
    i_Reset = 1'b1; i_Scan_Req = 1'b0; i_Wr_Valid = 1'b0; i_Clear = 1'b0;
    cycle();
    i_Reset = 1'b0; i_Clear = 1'b1; i_Clear_Color = 4'h7;
    for (int i = 1; i <= 17; i++) begin
      cycle();
      i_Clear       = (i == 5);
      i_Clear_Color = (i == 5) ? 4'h3 : 4'h7;
      i_Scan_Req    = ((i % 2) == 1) && (i < 16);
      i_Scan_Addr   = PAW'((2 * i) % 16);
      i_Wr_Valid    = (i < 17);
      i_Wr_Addr     = PAW'(1);
      i_Wr_Color    = 4'h5;
      #1;
      busyExp = (expPtr < 8);
      checks++;
      if (o_Clear_Busy !== busyExp || o_Wr_Ready !== !busyExp) begin
        errors++;
        $display("FAIL clr_busy[%0d]: got busy=%b ready=%b required busy=%b ready=%b",
                 i, o_Clear_Busy, o_Wr_Ready, busyExp, !busyExp);
      end
      if (busyExp && !i_Scan_Req) begin
        checks++;
        if (o_Mem_Wr_En !== 1'b1 || o_Mem_Addr !== WW'(expPtr) ||
            o_Mem_Wr_Mask !== 2'b11 || o_Mem_Wr_Data !== 8'h77) begin
          errors++;
          $display("FAIL clr_write[%0d]: got wr=%b addr=%h mask=%b data=%h required 1 %h 11 77",
                   i, o_Mem_Wr_En, o_Mem_Addr, o_Mem_Wr_Mask, o_Mem_Wr_Data, expPtr);
        end
        expPtr++;
      end else begin
        checks++;
        if (o_Mem_Wr_En !== 1'b0) begin
          errors++;
          $display("FAIL clr_no_write[%0d]: got wr=%b required 0", i, o_Mem_Wr_En);
        end
      end
    end
    i_Wr_Valid = 1'b0; i_Clear = 1'b0;
  endtask
`endif

  initial begin
    i_Reset = 1'b1; i_Scan_Req = 1'b0; i_Scan_Addr = '0;
    i_Wr_Valid = 1'b0; i_Wr_Addr = '0; i_Wr_Color = '0;
`ifdef FB_CLEAR_EN
    i_Clear = 1'b0; i_Clear_Color = '0;
`endif
    test_reset();
    test_scan_read();
    test_write_stall();
    test_coherent_write();
    test_overlay();
    test_reset_flush();
`ifdef FB_CLEAR_EN
    test_clear();
`endif
    cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
